// File: rtl/mips_pkg.sv
// Shared constants and helpers for the MIPS front end.
package mips_pkg;
   localparam int unsigned WORD_W   = 32;
   localparam logic [31:0] NOP      = 32'h0000_0000;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-unit bus: imem read port, decode handshake, redirect and occupancy.
interface fetch_queue_if #(
   parameter int unsigned IMEM_AW = 6,
   parameter int unsigned CNT_W   = 3
);
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_instr;
   logic               out_valid;
   logic               out_ready;
   logic [31:0]        out_instr;
   logic [31:0]        out_pc;
   logic               redirect_valid;
   logic [31:0]        redirect_pc;
   logic [CNT_W-1:0]   count;

   modport master (
      output imem_addr, out_valid, out_instr, out_pc, count,
      input  imem_instr, out_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_addr, out_valid, out_instr, out_pc, count,
      output imem_instr, out_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/fetch_queue_fifo.sv
// Prefetch storage: circular register array with flush; head data held once empty.
module fetch_fifo
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 64,
   localparam int unsigned PW   = clog2(DEPTH),
   localparam int unsigned CW   = clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic          valid,
   output logic [CW-1:0] count
);
   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] head, tail;
   logic [CW-1:0] cnt;
   logic [W-1:0]  hold;

   always_ff @(posedge clk) begin
      if (push && !flush) mem[tail] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
         hold <= '0;
      end else begin
         // hold tracks the visible head so an emptied queue keeps showing it
         if (cnt != '0) hold <= mem[head];
         if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
         end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            if (push && !pop)      cnt <= cnt + CW'(1);
            else if (pop && !push) cnt <= cnt - CW'(1);
         end
      end
   end

   always_comb begin
      valid = (cnt != '0);
      count = cnt;
      rdata = valid ? mem[head] : hold;
   end
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: owns fetch PC, drives imem, queues {instr,pc} for decode.
module fetch_queue
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned IMEM_AW  = 6,
   parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
   localparam int unsigned CNT_W   = clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   fetch_queue_if.master bus
);
   logic [31:0]       fetch_pc;
   logic              pop, push, fifo_valid;
   logic [63:0]       rdata;
   logic [CNT_W-1:0]  fifo_count;

   always_comb begin
      pop  = fifo_valid & bus.out_ready & ~bus.redirect_valid;
      push = ~bus.redirect_valid & ((fifo_count < CNT_W'(DEPTH)) | pop);
      bus.imem_addr = fetch_pc[IMEM_AW+1:2];
      bus.out_valid = fifo_valid;
      bus.out_instr = rdata[63:32];
      bus.out_pc    = rdata[31:0];
      bus.count     = fifo_count;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                  fetch_pc <= RESET_PC;
      else if (bus.redirect_valid) fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      else if (push)               fetch_pc <= fetch_pc + 32'd4;
   end

   fetch_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (push),
      .pop   (pop),
      .flush (bus.redirect_valid),
      .wdata ({bus.imem_instr, fetch_pc}),
      .rdata (rdata),
      .valid (fifo_valid),
      .count (fifo_count)
   );
endmodule

// File: tb/tb_fetch_queue.sv
// Random + directed bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
   localparam int unsigned DEPTH = 4;

   logic clk = 0;
   logic rst_n = 0;
   always #5 clk = ~clk;

   fetch_queue_if #(.IMEM_AW(6), .CNT_W(3)) bus ();

   fetch_queue #(.DEPTH(4), .IMEM_AW(6), .RESET_PC(32'h0)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   assign bus.imem_instr = 32'hA000_0000 + 32'(bus.imem_addr);

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   logic [63:0] q[$];
   logic [31:0] mpc;
   logic [63:0] last;

   function automatic logic [31:0] word_at(input logic [31:0] pc);
      return 32'hA000_0000 + ((pc >> 2) % 64);
   endfunction

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      mpc  = 32'h0;
      last = '0;
   endtask

   task automatic check_all();
      check_val("count", 64'(bus.count), 64'(q.size()));
      check_val("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
      check_val("imem_addr", 64'(bus.imem_addr), 64'((mpc >> 2) % 64));
      if (q.size() != 0) begin
         check_val("out_instr", 64'(bus.out_instr), 64'(q[0][63:32]));
         check_val("out_pc", 64'(bus.out_pc), 64'(q[0][31:0]));
         last = q[0];
      end else begin
         check_val("hold_instr", 64'(bus.out_instr), 64'(last[63:32]));
         check_val("hold_pc", 64'(bus.out_pc), 64'(last[31:0]));
      end
   endtask

   // One clock: reference update from the handshake rules, then compare.
   task automatic tick();
      bit pop, push;
      @(posedge clk);
      pop  = (q.size() != 0) && bus.out_ready && !bus.redirect_valid;
      push = !bus.redirect_valid && ((q.size() < DEPTH) || pop);
      if (bus.redirect_valid) begin
         q.delete();
         mpc = {bus.redirect_pc[31:2], 2'b00};
      end else begin
         if (pop) void'(q.pop_front());
         if (push) begin
            q.push_back({word_at(mpc), mpc});
            mpc = mpc + 32'd4;
         end
      end
      #1;
      check_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      model_reset();
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1;
   endtask

   logic [31:0] pre_head;

   initial begin
      bus.out_ready = 1;
      bus.redirect_valid = 0;
      bus.redirect_pc = '0;
      model_reset();

      // reset state and streaming at one per cycle
      do_reset();
      repeat (12) tick();
      check_val("t1_pc_after_12", 64'(bus.out_pc), 64'(32'h2C));

      // stall: queue saturates, imem_addr holds
      do_reset();
      bus.out_ready = 0;
      repeat (10) tick();
      check_val("t2_full", 64'(bus.count), 64'(4));
      check_val("t2_addr_hold", 64'(bus.imem_addr), 64'(4));
      bus.out_ready = 1;
      repeat (6) tick();

      // redirect with three entries queued
      do_reset();
      bus.out_ready = 0;
      repeat (3) tick();
      pre_head = bus.out_pc;
      bus.out_ready = 1;
      bus.redirect_valid = 1;
      bus.redirect_pc = 32'h43;
      tick();
      bus.redirect_valid = 0;
      check_val("t3_addr", 64'(bus.imem_addr), 64'(16));
      check_val("t3_hold_pc", 64'(bus.out_pc), 64'(pre_head));
      tick();
      check_val("t3_pc", 64'(bus.out_pc), 64'(32'h40));
      check_val("t3_instr", 64'(bus.out_instr), 64'(32'hA000_0010));

      // full queue with continuous drain
      bus.out_ready = 0;
      repeat (6) tick();
      bus.out_ready = 1;
      repeat (20) tick();

      // imem address wrap past word 63
      bus.redirect_valid = 1;
      bus.redirect_pc = 32'hE0;
      tick();
      bus.redirect_valid = 0;
      repeat (14) tick();

      // async reset mid-cycle with three entries queued
      do_reset();
      bus.out_ready = 0;
      repeat (3) tick();
      #2;
      rst_n = 0;
      #1;
      check_val("t6_valid", 64'(bus.out_valid), 64'(0));
      check_val("t6_count", 64'(bus.count), 64'(0));
      check_val("t6_pc", 64'(bus.out_pc), 64'(0));
      check_val("t6_instr", 64'(bus.out_instr), 64'(0));
      model_reset();
      @(negedge clk);
      rst_n = 1;
      bus.out_ready = 1;
      repeat (4) tick();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.redirect_valid = ($urandom_range(0, 15) == 0);
         bus.redirect_pc = $urandom;
         tick();
      end
      bus.redirect_valid = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
